// File: rtl/pir_motion_detector_pkg.sv
// Shared definitions for the PIR motion front-end: FSM state codes and the
// event-counter width/limit used by pir_motion_detector.
package pir_motion_detector_pkg;

   typedef enum logic [2:0] {
      ST_WARMUP  = 3'd0,
      ST_IDLE    = 3'd1,
      ST_CONFIRM = 3'd2,
      ST_ACTIVE  = 3'd3,
      ST_HOLD    = 3'd4
   } pir_state_e;

   localparam int                      EVENT_CNT_W   = 8;
   localparam logic [EVENT_CNT_W-1:0] EVENT_CNT_MAX = 8'd255;

   // Saturating increment for the detection counter.
   function automatic logic [EVENT_CNT_W-1:0] event_sat_inc(
      input logic [EVENT_CNT_W-1:0] v
   );
      return (v == EVENT_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pir_motion_detector_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level input.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/pir_motion_detector.sv
// PIR sensor conditioning: synchronize, mask warm-up, debounce, retriggerable hold.
// Define PIR_EVENT_COUNTER_EN to build the saturating event_count register.
module pir_motion_detector
   import pir_motion_detector_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES   = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 50_000,
   parameter int unsigned HOLD_CYCLES     = 100_000_000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pir_in,
   output logic                   ready,
   output logic                   motion_detected,
   output logic                   motion_event,
   output logic [EVENT_CNT_W-1:0] event_count
);

   localparam logic [CNT_W-1:0] WARMUP_LAST   = CNT_W'(WARMUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);

   logic pir_sync;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pir_in),
      .q     (pir_sync)
   );

   pir_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             md_q, md_d;
   logic             ev_q, ev_d;

   // One counter serves warm-up, debounce and hold; any state change clears it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      ready_d = ready_q;
      md_d    = md_q;
      ev_d    = 1'b0;
      case (state_q)
         ST_WARMUP: begin
            if (cnt_q == WARMUP_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ready_d = 1'b1;
            end
         end
         ST_IDLE: begin
            cnt_d = '0;
            if (pir_sync) state_d = ST_CONFIRM;
         end
         ST_CONFIRM: begin
            if (!pir_sync) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DEBOUNCE_LAST) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
               md_d    = 1'b1;
               ev_d    = 1'b1;
            end
         end
         ST_ACTIVE: begin
            cnt_d = '0;
            if (!pir_sync) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Retrigger wins over expiry in the same cycle.
            if (pir_sync) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               md_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_WARMUP;
            cnt_d   = '0;
            ready_d = 1'b0;
            md_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_WARMUP;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         md_q    <= 1'b0;
         ev_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         md_q    <= md_d;
         ev_q    <= ev_d;
      end
   end

   assign ready           = ready_q;
   assign motion_detected = md_q;
   assign motion_event    = ev_q;

`ifdef PIR_EVENT_COUNTER_EN
   logic [EVENT_CNT_W-1:0] ecnt_q, ecnt_d;

   always_comb begin
      ecnt_d = ecnt_q;
      if (ev_q) ecnt_d = event_sat_inc(ecnt_q);
   end

   always_ff @(posedge clk) begin
      if (reset) ecnt_q <= '0;
      else       ecnt_q <= ecnt_d;
   end

   assign event_count = ecnt_q;
`else
   assign event_count = '0;
`endif

endmodule

// File: tb/tb_pir_motion_detector.sv
// Bench for pir_motion_detector (WARMUP=20, DEBOUNCE=4, HOLD=10): segment table
// of expected output levels, scoreboard queue, plus a 260-detection saturation run.
module tb_pir_motion_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic       pir_in;
   logic       ready;
   logic       motion_detected;
   logic       motion_event;
   logic [7:0] event_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ev_seen = 0;

   typedef struct {
      logic  rst;
      logic  pir;
      int    n;
      logic  rdy;
      logic  md;
      logic  ev;
      string name;
   } seg_t;

   typedef struct {
      logic       rdy;
      logic       md;
      logic       ev;
      logic [7:0] cnt;
      string      name;
   } exp_t;

   seg_t       tbl[$];
   exp_t       sb[$];
   logic [7:0] exp_cnt = 8'd0;
   logic       prev_ev = 1'b0;

   always #5 clk = ~clk;

   pir_motion_detector #(
      .WARMUP_CYCLES   (20),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .CNT_W           (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pir_in          (pir_in),
      .ready           (ready),
      .motion_detected (motion_detected),
      .motion_event    (motion_event),
      .event_count     (event_count)
   );

   task automatic add(input logic r, input logic p, input int n,
                      input logic rdy, input logic md, input logic ev, input string name);
      seg_t s;
      s.rst = r; s.pir = p; s.n = n; s.rdy = rdy; s.md = md; s.ev = ev; s.name = name;
      tbl.push_back(s);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Drive one cycle, queue its expectation, compare once the edge has passed.
   task automatic run_cycle(input logic r, input logic p, input logic rdy,
                            input logic md, input logic ev, input string name);
      exp_t e, a;
      reset  = r;
      pir_in = p;
      if (r) exp_cnt = 8'd0;
`ifdef PIR_EVENT_COUNTER_EN
      else if (prev_ev && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
`endif
      prev_ev = ev;
      e.rdy = rdy; e.md = md; e.ev = ev; e.cnt = exp_cnt; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      a = sb.pop_front();
      if (motion_event === 1'b1) n_ev_seen++;
      n_cmp++;
      if (ready !== a.rdy || motion_detected !== a.md || motion_event !== a.ev ||
          event_count !== a.cnt) begin
         n_bad++;
         $display("FAIL %s: got rdy=%b md=%b ev=%b cnt=%0d, want rdy=%b md=%b ev=%b cnt=%0d",
                  a.name, ready, motion_detected, motion_event, event_count,
                  a.rdy, a.md, a.ev, a.cnt);
      end
   endtask

   initial begin
      reset  = 1'b1;
      pir_in = 1'b1;

      //   rst  pir  n   rdy  md   ev
      add(1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, "reset");
      add(1'b0, 1'b1, 19, 1'b0, 1'b0, 1'b0, "warmup_masked");
      add(1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b0, "s1_ready_confirm");
      add(1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, "s1_event");
      add(1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b0, "s1_active");
      add(1'b0, 1'b0, 12, 1'b1, 1'b1, 1'b0, "s1_hold");
      add(1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b0, "s1_idle");
      add(1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b0, "s2_glitch");
      add(1'b0, 1'b0, 8,  1'b1, 1'b0, 1'b0, "s2_idle");
      add(1'b0, 1'b1, 6,  1'b1, 1'b0, 1'b0, "s3_confirm");
      add(1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, "s3_event");
      add(1'b0, 1'b1, 23, 1'b1, 1'b1, 1'b0, "s3_active");
      add(1'b0, 1'b0, 12, 1'b1, 1'b1, 1'b0, "s3_hold");
      add(1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b0, "s3_idle");
      add(1'b0, 1'b1, 6,  1'b1, 1'b0, 1'b0, "s4_confirm");
      add(1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, "s4_event");
      add(1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, "s4_active");
      add(1'b0, 1'b0, 6,  1'b1, 1'b1, 1'b0, "s4_hold");
      add(1'b0, 1'b1, 4,  1'b1, 1'b1, 1'b0, "s4_retrigger");
      add(1'b0, 1'b0, 12, 1'b1, 1'b1, 1'b0, "s4_hold_restart");
      add(1'b0, 1'b0, 5,  1'b1, 1'b0, 1'b0, "s4_idle");
      add(1'b0, 1'b1, 6,  1'b1, 1'b0, 1'b0, "s5_confirm");
      add(1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, "s5_event");
      add(1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0, "s5_active");
      add(1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, "s5_reset");
      add(1'b0, 1'b0, 19, 1'b0, 1'b0, 1'b0, "s5_rewarm");
      add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, "s5_ready");
      add(1'b0, 1'b1, 5,  1'b1, 1'b0, 1'b0, "min_high");
      add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, "min_wait");
      add(1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b1, "min_event");
      add(1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, "min_hold");
      add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, "min_idle");
      add(1'b0, 1'b1, 4,  1'b1, 1'b0, 1'b0, "abort4_high");
      add(1'b0, 1'b0, 8,  1'b1, 1'b0, 1'b0, "abort4_idle");

      foreach (tbl[i])
         for (int k = 0; k < tbl[i].n; k++)
            run_cycle(tbl[i].rst, tbl[i].pir, tbl[i].rdy, tbl[i].md, tbl[i].ev, tbl[i].name);

      // 260 back-to-back detections; one event already counted since the last reset.
      n_ev_seen = 0;
      for (int d = 0; d < 260; d++) begin
         for (int k = 0; k < 6; k++)  run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sat_confirm");
         run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "sat_event");
         for (int k = 0; k < 12; k++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "sat_hold");
         for (int k = 0; k < 2; k++)  run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "sat_idle");
`ifdef PIR_EVENT_COUNTER_EN
         if (d == 253) chk("sat_reach_255", int'(event_count), 255);
`else
         if (d == 253) chk("cnt_tied_zero_mid", int'(event_count), 0);
`endif
      end
      chk("sat_event_pulses", n_ev_seen, 260);
`ifdef PIR_EVENT_COUNTER_EN
      chk("sat_hold_255", int'(event_count), 255);
`else
      chk("cnt_tied_zero_end", int'(event_count), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
